seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 84 ++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector: runtime-loadable PAT_W-bit pattern, optional overlap, saturating match counter.
// Latency 1 cycle (registered out pulse); no backpressure, a bit is consumed on every edge with in_valid=1.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);
    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAT_W-1:0]  shifted;
    logic              match;

    always_comb begin
        shifted = {hist_q[PAT_W-2:0], i};
        // Fill gating keeps a zero-filled history from matching leading-zero patterns.
        match   = in_valid && !pat_load && (fill_q >= FILL_ARM) && (shifted == pat_q);
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else begin
            out_d = match;
            if (in_valid) begin
                hist_d = shifted;
                if (match && (OVERLAP == 0)) begin
                    fill_d = '0;
                end else if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end

        if (count_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= PATTERN;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out         = out_q;
    assign match_count = cnt_q;

endmodule
